// File: rtl/abs_poll_ctrl.sv
// Transaction sequencer for the RS485 absolute-encoder link: merges periodic and
// on-demand reads, supervises each with a timeout, retries after a gap, latches good frames.
module abs_poll_ctrl #(
   parameter int CLK_PER_US = 30,
   parameter int TIMEOUT_US = 130,
   parameter int GAP_US     = 20,
   parameter int MAX_RETRY  = 3
) (
   input  logic        clk_in,
   input  logic        sys_rst,
   input  logic        poll_en,
   input  logic [15:0] poll_period,
   input  logic        dsp_req,
   output logic        read_begin,
   input  logic        rx_done,
   input  logic        rx_err,
   input  logic [63:0] rx_data,
   output logic [63:0] pos_data,
   output logic        pos_valid,
   output logic        busy,
   output logic        fault,
   input  logic        fault_clr,
   output logic [7:0]  err_cnt
);

   localparam int TMO_CYC   = TIMEOUT_US * CLK_PER_US;
   localparam int GAP_TICKS = (GAP_US < 1) ? 1 : GAP_US;
   localparam int PRE_W     = $clog2(CLK_PER_US + 1);
   localparam int TMO_W     = $clog2(TMO_CYC + 1);
   localparam int GAP_W     = $clog2(GAP_TICKS + 1);
   localparam int RTY_W     = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

   state_t           state, state_nxt;
   logic [PRE_W-1:0] presc;
   logic             us_tick;
   logic [15:0]      poll_cnt;
   logic             poll_pend;
   logic             poll_active;
   logic             dsp_pend;
   logic             req_any;
   logic             take_req;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             gap_done;
   logic [RTY_W-1:0] retry_cnt;
   logic [RTY_W-1:0] retry_nxt;
   logic             last_try;
   logic             rx_ok;
   logic             fail_evt;
   logic             fault_set;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign us_tick = (presc == PRE_W'(CLK_PER_US - 1));

   always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst)      presc <= '0;
      else if (us_tick) presc <= '0;
      else              presc <= presc + 1'b1;
   end

   // The periodic source is muted by fault; a pend raised just before the fault is masked too.
   assign poll_active = poll_en && (poll_period != 16'd0) && !fault;
   assign req_any     = (poll_pend && !fault) || dsp_pend || dsp_req;
   assign take_req    = (state == IDLE) && req_any;

   always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst) begin
         poll_cnt  <= '0;
         poll_pend <= 1'b0;
      end else if (!poll_active) begin
         poll_cnt  <= '0;
         poll_pend <= 1'b0;
      end else begin
         if (take_req) poll_pend <= 1'b0;
         if (us_tick) begin
            if (poll_cnt >= poll_period - 16'd1) begin
               poll_cnt  <= '0;
               poll_pend <= 1'b1;
            end else begin
               poll_cnt <= poll_cnt + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst)       dsp_pend <= 1'b0;
      else if (take_req) dsp_pend <= 1'b0;
      else if (dsp_req)  dsp_pend <= 1'b1;
   end

   // A frame in the last window cycle still counts; an error wins over a simultaneous done.
   assign rx_ok     = (state == WAIT) && rx_done && !rx_err;
   assign fail_evt  = (state == WAIT) && (rx_err || (!rx_done && tmo_cnt == TMO_W'(1)));
   assign retry_nxt = retry_cnt + 1'b1;
   assign last_try  = (retry_nxt >= RTY_W'(MAX_RETRY));
   assign fault_set = fail_evt && last_try;
   assign gap_done  = us_tick && (gap_cnt == GAP_W'(GAP_TICKS - 1));

   always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      read_begin = 1'b0;
      case (state)
         IDLE:  if (req_any) state_nxt = ISSUE;
         ISSUE: begin
            read_begin = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            if (rx_ok)         state_nxt = IDLE;
            else if (fail_evt) state_nxt = last_try ? IDLE : GAP;
         end
         GAP:   if (gap_done) state_nxt = ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst) begin
         tmo_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         if (state == ISSUE)                          tmo_cnt <= TMO_W'(TMO_CYC);
         else if (state == WAIT && tmo_cnt != '0)     tmo_cnt <= tmo_cnt - 1'b1;
         if (state != GAP)                            gap_cnt <= '0;
         else if (us_tick)                            gap_cnt <= gap_cnt + 1'b1;
      end
   end

   // Setting the fault takes priority over a coincident fault_clr.
   always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst) begin
         retry_cnt <= '0;
         fault     <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         if (fault_set)      retry_cnt <= '0;
         else if (fail_evt)  retry_cnt <= retry_nxt;
         else if (rx_ok)     retry_cnt <= '0;
         else if (fault_clr) retry_cnt <= '0;

         if (fault_set)      fault <= 1'b1;
         else if (fault_clr) fault <= 1'b0;

         if (fail_evt) err_cnt <= sat_inc8(err_cnt);
      end
   end

   always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst) begin
         pos_data  <= 64'd0;
         pos_valid <= 1'b0;
      end else begin
         pos_valid <= rx_ok;
         if (rx_ok) pos_data <= rx_data;
      end
   end

endmodule

// File: tb/tb_abs_poll_ctrl.sv
// Directed bench for abs_poll_ctrl: default-parameter instance for timing scenarios,
// a small-parameter instance for error-counter saturation.
module tb_abs_poll_ctrl;

   logic        clk_in = 1'b0;
   logic        sys_rst;
   logic        poll_en, dsp_req, rx_done, rx_err, fault_clr;
   logic [15:0] poll_period;
   logic [63:0] rx_data;
   logic        read_begin, pos_valid, busy, fault;
   logic [63:0] pos_data;
   logic [7:0]  err_cnt;

   logic        s_poll_en, s_dsp_req, s_rx_done, s_rx_err, s_fault_clr;
   logic [15:0] s_poll_period;
   logic [63:0] s_rx_data;
   logic        s_read_begin, s_pos_valid, s_busy, s_fault;
   logic [63:0] s_pos_data;
   logic [7:0]  s_err_cnt;

   int          cyc = 0;
   int          tests_run = 0;
   int          failed = 0;
   int          exp_err = 0;
   logic [63:0] last_good = 64'd0;

   localparam logic [63:0] FRAME_A = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] FRAME_B = 64'hDEAD_BEEF_0000_1111;
   localparam logic [63:0] FRAME_C = 64'h5555_AAAA_1234_8765;

   abs_poll_ctrl u_dut (
      .clk_in(clk_in), .sys_rst(sys_rst), .poll_en(poll_en), .poll_period(poll_period),
      .dsp_req(dsp_req), .read_begin(read_begin), .rx_done(rx_done), .rx_err(rx_err),
      .rx_data(rx_data), .pos_data(pos_data), .pos_valid(pos_valid), .busy(busy),
      .fault(fault), .fault_clr(fault_clr), .err_cnt(err_cnt)
   );

   abs_poll_ctrl #(.CLK_PER_US(2), .TIMEOUT_US(4), .GAP_US(1), .MAX_RETRY(3)) u_sat (
      .clk_in(clk_in), .sys_rst(sys_rst), .poll_en(s_poll_en), .poll_period(s_poll_period),
      .dsp_req(s_dsp_req), .read_begin(s_read_begin), .rx_done(s_rx_done), .rx_err(s_rx_err),
      .rx_data(s_rx_data), .pos_data(s_pos_data), .pos_valid(s_pos_valid), .busy(s_busy),
      .fault(s_fault), .fault_clr(s_fault_clr), .err_cnt(s_err_cnt)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_rb(input int bound, output int k, output bit ok);
      ok = 1'b0;
      k  = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         tick();
         if (read_begin) begin
            ok = 1'b1;
            k  = cyc;
         end
      end
   endtask

   task automatic answer(input logic [63:0] d);
      rx_data = d;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic pulse_dsp();
      dsp_req = 1'b1;
      tick();
      dsp_req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_in);
      #1;
      tests_run++;
      if ({read_begin, pos_valid, busy, fault} !== 4'b0000 || pos_data !== 64'd0 || err_cnt !== 8'd0) begin
         failed++;
         $display("FAIL reset_outputs: rb=%0b pv=%0b busy=%0b fault=%0b data=%0h err=%0d, required all 0",
                  read_begin, pos_valid, busy, fault, pos_data, err_cnt);
      end
      sys_rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      rx_data = FRAME_B;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
      tests_run++;
      if (pos_valid !== 1'b0 || pos_data !== 64'd0) begin
         failed++;
         $display("FAIL idle_rx_ignored: pv=%0b data=%0h, required 0/0", pos_valid, pos_data);
      end
      pulse_dsp();
      tests_run++;
      if (read_begin !== 1'b1 || busy !== 1'b1) begin
         failed++;
         $display("FAIL dsp_start: rb=%0b busy=%0b, required 1/1", read_begin, busy);
      end
      tick();
      tests_run++;
      if (read_begin !== 1'b0 || busy !== 1'b1) begin
         failed++;
         $display("FAIL dsp_wait: rb=%0b busy=%0b, required 0/1", read_begin, busy);
      end
      answer(FRAME_C);
      last_good = FRAME_C;
      tests_run++;
      if (pos_valid !== 1'b1 || pos_data !== FRAME_C || busy !== 1'b0) begin
         failed++;
         $display("FAIL dsp_success: pv=%0b data=%0h busy=%0b, required 1/%0h/0", pos_valid, pos_data, busy, FRAME_C);
      end
      tick();
      tests_run++;
      if (pos_valid !== 1'b0) begin
         failed++;
         $display("FAIL pos_valid_pulse: got %0b, required 0", pos_valid);
      end
   endtask

   task automatic test_reset_mid_wait();
      int rb_seen;
      pulse_dsp();
      tick();
      #3 sys_rst = 1'b1;
      #1;
      tests_run++;
      if ({read_begin, pos_valid, busy, fault} !== 4'b0000 || pos_data !== 64'd0 || err_cnt !== 8'd0) begin
         failed++;
         $display("FAIL async_reset: rb=%0b pv=%0b busy=%0b fault=%0b data=%0h err=%0d, required all 0",
                  read_begin, pos_valid, busy, fault, pos_data, err_cnt);
      end
      last_good = 64'd0;
      #2 sys_rst = 1'b0;
      rb_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (read_begin) rb_seen++;
      end
      tests_run++;
      if (rb_seen !== 0) begin
         failed++;
         $display("FAIL reset_no_issue: got %0d read_begin, required 0", rb_seen);
      end
   endtask

   task automatic test_periodic();
      int k, kp;
      bit ok;
      poll_en     = 1'b1;
      poll_period = 16'd100;
      for (int n = 0; n < 3; n++) begin
         wait_rb((n == 0) ? 3100 : 3000, k, ok);
         tests_run++;
         if (!ok) begin
            failed++;
            $display("FAIL poll_issue%0d: no read_begin within bound, required one", n);
         end
         if (n > 0) begin
            tests_run++;
            if (k - kp < 2999 || k - kp > 3001) begin
               failed++;
               $display("FAIL poll_period%0d: interval %0d cycles, required 3000+-1", n, k - kp);
            end
         end
         kp = k;
         repeat (499) tick();
         answer(FRAME_A);
         last_good = FRAME_A;
         tests_run++;
         if (pos_valid !== 1'b1 || pos_data !== FRAME_A || err_cnt !== 8'(exp_err)) begin
            failed++;
            $display("FAIL poll_frame%0d: pv=%0b data=%0h err=%0d, required 1/%0h/%0d",
                     n, pos_valid, pos_data, err_cnt, FRAME_A, exp_err);
         end
      end
      poll_en = 1'b0;
      tick();
   endtask

   task automatic test_timeout_recovery();
      int k, k2;
      bit ok;
      pulse_dsp();
      k = cyc;
      repeat (3900) tick();
      tests_run++;
      if (err_cnt !== 8'(exp_err) || busy !== 1'b1) begin
         failed++;
         $display("FAIL tmo_last_window: err=%0d busy=%0b, required %0d/1", err_cnt, busy, exp_err);
      end
      tick();
      exp_err++;
      tests_run++;
      if (err_cnt !== 8'(exp_err) || fault !== 1'b0 || busy !== 1'b1) begin
         failed++;
         $display("FAIL tmo_fail: err=%0d fault=%0b busy=%0b, required %0d/0/1", err_cnt, fault, busy, exp_err);
      end
      wait_rb(700, k2, ok);
      tests_run++;
      if (!ok || k2 - k < 4469 || k2 - k > 4531) begin
         failed++;
         $display("FAIL tmo_retry: ok=%0b spacing %0d, required about 4500", ok, k2 - k);
      end
      tick();
      answer(FRAME_B);
      last_good = FRAME_B;
      tests_run++;
      if (pos_valid !== 1'b1 || pos_data !== FRAME_B || err_cnt !== 8'(exp_err) || fault !== 1'b0) begin
         failed++;
         $display("FAIL tmo_recover: pv=%0b data=%0h err=%0d fault=%0b, required 1/%0h/%0d/0",
                  pos_valid, pos_data, err_cnt, fault, FRAME_B, exp_err);
      end
   endtask

   task automatic test_window_edge();
      pulse_dsp();
      repeat (3899) tick();
      answer(FRAME_A);
      last_good = FRAME_A;
      tests_run++;
      if (pos_valid !== 1'b1 || pos_data !== FRAME_A || err_cnt !== 8'(exp_err) || busy !== 1'b0) begin
         failed++;
         $display("FAIL window_edge: pv=%0b data=%0h err=%0d busy=%0b, required 1/%0h/%0d/0",
                  pos_valid, pos_data, err_cnt, busy, FRAME_A, exp_err);
      end
   endtask

   task automatic test_done_and_err();
      int k;
      bit ok;
      pulse_dsp();
      tick();
      rx_data = FRAME_C;
      rx_done = 1'b1;
      rx_err  = 1'b1;
      tick();
      rx_done = 1'b0;
      rx_err  = 1'b0;
      exp_err++;
      tests_run++;
      if (pos_valid !== 1'b0 || pos_data !== last_good || err_cnt !== 8'(exp_err) || busy !== 1'b1) begin
         failed++;
         $display("FAIL err_wins: pv=%0b data=%0h err=%0d busy=%0b, required 0/%0h/%0d/1",
                  pos_valid, pos_data, err_cnt, busy, last_good, exp_err);
      end
      wait_rb(700, k, ok);
      tests_run++;
      if (!ok) begin
         failed++;
         $display("FAIL err_retry: no retry read_begin, required one after gap");
      end
      tick();
      answer(FRAME_C);
      last_good = FRAME_C;
      tests_run++;
      if (pos_valid !== 1'b1 || pos_data !== FRAME_C) begin
         failed++;
         $display("FAIL err_recover: pv=%0b data=%0h, required 1/%0h", pos_valid, pos_data, FRAME_C);
      end
   endtask

   task automatic test_back_to_back();
      int rb_seen;
      pulse_dsp();
      for (int i = 0; i < 3; i++) begin
         tick();
         pulse_dsp();
      end
      answer(FRAME_B);
      last_good = FRAME_B;
      tests_run++;
      if (pos_valid !== 1'b1 || busy !== 1'b0) begin
         failed++;
         $display("FAIL b2b_first: pv=%0b busy=%0b, required 1/0", pos_valid, busy);
      end
      tick();
      tests_run++;
      if (read_begin !== 1'b1) begin
         failed++;
         $display("FAIL b2b_reissue: rb=%0b, required 1", read_begin);
      end
      tick();
      answer(FRAME_A);
      last_good = FRAME_A;
      rb_seen = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (read_begin) rb_seen++;
      end
      tests_run++;
      if (rb_seen !== 0) begin
         failed++;
         $display("FAIL b2b_collapse: got %0d extra read_begin, required 0", rb_seen);
      end
   endtask

   task automatic test_fault();
      int k, rb_seen;
      bit ok;
      poll_en     = 1'b1;
      poll_period = 16'd100;
      wait_rb(3100, k, ok);
      tests_run++;
      if (!ok) begin
         failed++;
         $display("FAIL fault_attempt1: no read_begin, required one");
      end
      for (int n = 2; n <= 3; n++) begin
         wait_rb(5000, k, ok);
         tests_run++;
         if (!ok) begin
            failed++;
            $display("FAIL fault_attempt%0d: no read_begin, required one", n);
         end
      end
      repeat (3900) tick();
      tests_run++;
      if (fault !== 1'b0) begin
         failed++;
         $display("FAIL fault_early: fault=%0b, required 0", fault);
      end
      tick();
      exp_err += 3;
      tests_run++;
      if (fault !== 1'b1 || err_cnt !== 8'(exp_err) || busy !== 1'b0) begin
         failed++;
         $display("FAIL fault_set: fault=%0b err=%0d busy=%0b, required 1/%0d/0", fault, err_cnt, busy, exp_err);
      end
      rb_seen = 0;
      for (int i = 0; i < 3500; i++) begin
         tick();
         if (read_begin) rb_seen++;
      end
      tests_run++;
      if (rb_seen !== 0) begin
         failed++;
         $display("FAIL fault_poll_stops: got %0d read_begin, required 0", rb_seen);
      end
      pulse_dsp();
      tests_run++;
      if (read_begin !== 1'b1) begin
         failed++;
         $display("FAIL fault_dsp_served: rb=%0b, required 1", read_begin);
      end
      tick();
      answer(FRAME_C);
      last_good = FRAME_C;
      tests_run++;
      if (pos_valid !== 1'b1 || pos_data !== FRAME_C || fault !== 1'b1) begin
         failed++;
         $display("FAIL fault_sticky: pv=%0b data=%0h fault=%0b, required 1/%0h/1", pos_valid, pos_data, fault, FRAME_C);
      end
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      tests_run++;
      if (fault !== 1'b0) begin
         failed++;
         $display("FAIL fault_clr: fault=%0b, required 0", fault);
      end
      wait_rb(3100, k, ok);
      tests_run++;
      if (!ok) begin
         failed++;
         $display("FAIL fault_poll_resume: no read_begin, required one");
      end
      tick();
      answer(FRAME_A);
      last_good = FRAME_A;
      poll_en = 1'b0;
      tick();
   endtask

   task automatic test_err_saturation();
      int n;
      s_dsp_req = 1'b1;
      s_rx_err  = 1'b1;
      n = 0;
      for (int i = 0; i < 3000 && n < 300; i++) begin
         s_fault_clr = (i % 25 == 0);
         tick();
         if (s_read_begin) begin
            n++;
            if (n == 100 || n == 256 || n == 257) begin
               tests_run++;
               if (s_err_cnt !== ((n == 257) ? 8'd255 : 8'(n - 1))) begin
                  failed++;
                  $display("FAIL sat_count%0d: err=%0d, required %0d", n, s_err_cnt, (n == 257) ? 255 : n - 1);
               end
            end
         end
      end
      s_dsp_req   = 1'b0;
      s_rx_err    = 1'b0;
      s_fault_clr = 1'b0;
      repeat (10) tick();
      tests_run++;
      if (n < 300 || s_err_cnt !== 8'd255) begin
         failed++;
         $display("FAIL sat_final: attempts=%0d err=%0d, required >=300/255", n, s_err_cnt);
      end
   endtask

   initial begin
      sys_rst = 1'b1;
      poll_en = 1'b0; poll_period = 16'd0; dsp_req = 1'b0;
      rx_done = 1'b0; rx_err = 1'b0; rx_data = 64'd0; fault_clr = 1'b0;
      s_poll_en = 1'b0; s_poll_period = 16'd0; s_dsp_req = 1'b0;
      s_rx_done = 1'b0; s_rx_err = 1'b0; s_rx_data = 64'd0; s_fault_clr = 1'b0;

      test_reset();
      test_single();
      test_reset_mid_wait();
      test_periodic();
      test_timeout_recovery();
      test_window_edge();
      test_done_and_err();
      test_back_to_back();
      test_fault();
      test_err_saturation();

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
